// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the core (priority) and DMA, with a core-streak cap.
// Grant is combinational, read/error response is registered one cycle later; the loser simply sees gnt=0 and holds.
module data_memory_arbiter #(
    parameter int DEPTH           = 1024,
    parameter int MAX_CORE_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        memoryReadEnable,
    output logic        memoryWriteEnable,
    output logic [31:0] memoryAddress,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    localparam int          SW        = $clog2(MAX_CORE_STREAK + 1);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CORE_STREAK);

    logic [SW-1:0] r_streak;
    logic          r_c_rvalid, r_c_err, r_d_rvalid, r_d_err;
    logic [31:0]   r_c_rdata, r_d_rdata;

    logic          w_dma_turn;
    logic          w_c_win, w_d_win;
    logic          w_c_in_range, w_d_in_range;
    logic          w_sel_we, w_sel_in_range;
    logic [31:0]   w_sel_addr, w_sel_wdata;

    assign w_c_in_range = (c_addr < DEPTH_W);
    assign w_d_in_range = (d_addr < DEPTH_W);

    // DMA overrides core priority only once the core has won MAX_CORE_STREAK times in a row.
    assign w_dma_turn = (r_streak == STREAK_MAX);
    assign w_c_win    = !reset && c_req && (!d_req || !w_dma_turn);
    assign w_d_win    = !reset && d_req && (!c_req ||  w_dma_turn);

    assign c_gnt = w_c_win;
    assign d_gnt = w_d_win;

    always_comb begin
        w_sel_we       = 1'b0;
        w_sel_in_range = 1'b0;
        w_sel_addr     = '0;
        w_sel_wdata    = '0;
        if (w_c_win) begin
            w_sel_we       = c_we;
            w_sel_in_range = w_c_in_range;
            w_sel_addr     = c_addr;
            w_sel_wdata    = c_wdata;
        end else if (w_d_win) begin
            w_sel_we       = d_we;
            w_sel_in_range = w_d_in_range;
            w_sel_addr     = d_addr;
            w_sel_wdata    = d_wdata;
        end
    end

    assign memoryReadEnable  = (w_c_win || w_d_win) && !w_sel_we && w_sel_in_range;
    assign memoryWriteEnable = (w_c_win || w_d_win) &&  w_sel_we && w_sel_in_range;
    assign memoryAddress     = w_sel_addr;
    assign writeData         = w_sel_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_d_win || !d_req) begin
            r_streak <= '0;
        end else if (w_c_win && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    // Out-of-range reads still return rvalid with zero data so a stalled load can retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c_rvalid <= 1'b0;
            r_c_err    <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_c_win && !c_we;
            r_c_err    <= w_c_win && !w_c_in_range;
            r_d_rvalid <= w_d_win && !d_we;
            r_d_err    <= w_d_win && !w_d_in_range;
            if (w_c_win && !c_we) begin
                r_c_rdata <= w_c_in_range ? readData : 32'h0;
            end
            if (w_d_win && !d_we) begin
                r_d_rdata <= w_d_in_range ? readData : 32'h0;
            end
        end
    end

    assign c_rvalid = r_c_rvalid;
    assign c_err    = r_c_err;
    assign c_rdata  = r_c_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized and directed bench for data_memory_arbiter against a behavioural arbitration/memory model.
module tb_data_memory_arbiter;

    localparam int DEPTH = 1024;
    localparam int MAXS  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        memoryReadEnable, memoryWriteEnable;
    logic [31:0] memoryAddress, writeData, readData;

    always #5 clock = ~clock;

    data_memory_arbiter #(.DEPTH(DEPTH), .MAX_CORE_STREAK(MAXS)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .memoryAddress(memoryAddress), .writeData(writeData), .readData(readData)
    );

    // Environment memory attached to the DUT pins.
    logic [31:0] env_mem [DEPTH];
    logic        mem_clear;
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= '0;
        end else if (memoryWriteEnable) begin
            env_mem[memoryAddress[9:0]] <= writeData;
        end
    end
    assign readData = env_mem[memoryAddress[9:0]];

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          m_streak;
    logic        exp_c_rvalid, exp_c_err, exp_d_rvalid, exp_d_err;
    logic [31:0] exp_c_rdata, exp_d_rdata;
    int          n_checks, n_errors;
    int          dma_wait;
    int          last_win;
    logic        last_c_gnt, last_d_gnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd1024;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1023;
            3:       return $urandom;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    // Called at the falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        int          w;
        logic [31:0] ea, ed;
        logic        ere, ewe;
        #1;
        if (reset)                                     w = 0;
        else if (d_req && (!c_req || m_streak == MAXS)) w = 2;
        else if (c_req)                                w = 1;
        else                                           w = 0;
        ea = '0; ed = '0; ere = 1'b0; ewe = 1'b0;
        if (w == 1) begin
            ea = c_addr; ed = c_wdata; ere = !c_we && in_range(c_addr); ewe = c_we && in_range(c_addr);
        end else if (w == 2) begin
            ea = d_addr; ed = d_wdata; ere = !d_we && in_range(d_addr); ewe = d_we && in_range(d_addr);
        end
        check("c_gnt", 32'(c_gnt), 32'(w == 1));
        check("d_gnt", 32'(d_gnt), 32'(w == 2));
        check("mem_re", 32'(memoryReadEnable), 32'(ere));
        check("mem_we", 32'(memoryWriteEnable), 32'(ewe));
        check("mem_addr", memoryAddress, ea);
        check("mem_wdata", writeData, ed);
        last_win = w; last_c_gnt = c_gnt; last_d_gnt = d_gnt;

        if (reset) dma_wait = 0;
        else if (w == 2) begin
            check("dma_wait_bound", 32'(dma_wait <= MAXS), 32'd1);
            dma_wait = 0;
        end else if (d_req) dma_wait++;
        else dma_wait = 0;

        if (reset) begin
            m_streak = 0;
            exp_c_rvalid = 0; exp_c_err = 0; exp_c_rdata = '0;
            exp_d_rvalid = 0; exp_d_err = 0; exp_d_rdata = '0;
        end else begin
            exp_c_rvalid = (w == 1) && !c_we;
            exp_c_err    = (w == 1) && !in_range(c_addr);
            exp_d_rvalid = (w == 2) && !d_we;
            exp_d_err    = (w == 2) && !in_range(d_addr);
            if (w == 1 && !c_we) exp_c_rdata = in_range(c_addr) ? ref_mem[c_addr[9:0]] : 32'h0;
            if (w == 2 && !d_we) exp_d_rdata = in_range(d_addr) ? ref_mem[d_addr[9:0]] : 32'h0;
            if (w == 1 && c_we && in_range(c_addr)) ref_mem[c_addr[9:0]] = c_wdata;
            if (w == 2 && d_we && in_range(d_addr)) ref_mem[d_addr[9:0]] = d_wdata;
            if (w == 2 || !d_req)              m_streak = 0;
            else if (w == 1 && m_streak < MAXS) m_streak++;
        end

        @(posedge clock);
        #1;
        check("c_rvalid", 32'(c_rvalid), 32'(exp_c_rvalid));
        check("c_err", 32'(c_err), 32'(exp_c_err));
        check("c_rdata", c_rdata, exp_c_rdata);
        check("d_rvalid", 32'(d_rvalid), 32'(exp_d_rvalid));
        check("d_err", 32'(d_err), 32'(exp_d_err));
        check("d_rdata", d_rdata, exp_d_rdata);
        @(negedge clock);
    endtask

    task automatic set_c(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        c_req = req; c_we = we; c_addr = a; c_wdata = d;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        d_req = req; d_we = we; d_addr = a; d_wdata = d;
    endtask

    initial begin
        bit c_pend, d_pend;
        n_checks = 0; n_errors = 0; dma_wait = 0; m_streak = 0; last_win = 0;
        last_c_gnt = 0; last_d_gnt = 0;
        exp_c_rvalid = 0; exp_c_err = 0; exp_c_rdata = '0;
        exp_d_rvalid = 0; exp_d_err = 0; exp_d_rdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset = 1'b1; mem_clear = 1'b1;
        set_c(0, 0, 0, 0); set_d(0, 0, 0, 0);
        @(negedge clock);
        step();
        step();
        mem_clear = 1'b0;
        reset = 1'b0;

        // Core write then read of address 5.
        set_c(1, 1, 32'd5, 32'hDEAD_BEEF); step();
        set_c(1, 0, 32'd5, 32'h0); step();
        check("t1_rdata", c_rdata, 32'hDEAD_BEEF);
        check("t1_rvalid", 32'(c_rvalid), 32'd1);
        set_c(0, 0, 0, 0); step();

        // Simultaneous single requests: core first, then DMA.
        set_c(1, 0, 32'd3, 32'h0); set_d(1, 0, 32'd5, 32'h0); step();
        check("t2_core_first", 32'(last_c_gnt), 32'd1);
        set_c(0, 0, 0, 0); step();
        check("t2_dma_second", 32'(last_d_gnt), 32'd1);
        set_d(0, 0, 0, 0); step();

        // Continuous contention: C,C,C,C,D repeating.
        set_c(1, 0, 32'd1, 32'h0); set_d(1, 0, 32'd2, 32'h0);
        for (int i = 0; i < 15; i++) begin
            step();
            check("t3_pattern", 32'(last_d_gnt), 32'((i % 5) == 4));
        end
        set_c(0, 0, 0, 0); set_d(0, 0, 0, 0); step();

        // Out-of-range DMA read and write.
        set_d(1, 0, 32'd1024, 32'h0); step();
        check("t4_rd_err", 32'(d_err), 32'd1);
        check("t4_rd_rvalid", 32'(d_rvalid), 32'd1);
        check("t4_rd_rdata", d_rdata, 32'h0);
        set_d(1, 1, 32'hFFFF_FFFF, 32'h1234_5678); step();
        check("t4_wr_err", 32'(d_err), 32'd1);
        check("t4_wr_rvalid", 32'(d_rvalid), 32'd0);
        set_d(1, 0, 32'd1023, 32'h0); step();
        check("t4_mem_untouched", d_rdata, 32'h0);
        set_d(0, 0, 0, 0); step();

        // Reset during the grant cycle of a core read.
        set_c(1, 0, 32'd5, 32'h0); reset = 1'b1; step();
        reset = 1'b0; set_c(0, 0, 0, 0); step();
        check("t5_no_rvalid", 32'(c_rvalid), 32'd0);
        // Build a full streak, reset, and confirm the core wins first again.
        set_c(1, 0, 32'd1, 32'h0); set_d(1, 0, 32'd2, 32'h0);
        for (int i = 0; i < MAXS; i++) step();
        reset = 1'b1; step();
        reset = 1'b0; step();
        check("t5_core_first", 32'(last_c_gnt), 32'd1);
        set_c(0, 0, 0, 0); set_d(0, 0, 0, 0); step();

        // Back-to-back write then read.
        set_c(1, 1, 32'd7, 32'h11); step();
        set_c(1, 0, 32'd7, 32'h0); step();
        check("t6_rdata", c_rdata, 32'h11);
        set_c(0, 0, 0, 0); step();

        // Randomized traffic; requests are held until the model grants them.
        c_pend = 0; d_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!c_pend && $urandom_range(0, 3) != 0) begin
                c_pend = 1;
                set_c(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1;
                set_d(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            c_req = c_pend; d_req = d_pend;
            step();
            if (last_win == 1) c_pend = 0;
            if (last_win == 2) d_pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
